// File: rtl/pause_pkg.sv
// Shared definitions for the pause fade stage.
// Holds the FSM state encoding, the brightness scale (levels are eighths,
// 8 = full) and the counter widths used by pause_fade.
package pause_pkg;

  localparam int LEVEL_BITS = 4;
  localparam logic [LEVEL_BITS-1:0] LEVEL_FULL = 4'd8;

  localparam int PRESC_BITS = 28;
  localparam int SECS_BITS  = 8;
  localparam int FRAME_BITS = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT     = 3'd1,
    S_FADE_OUT = 3'd2,
    S_DIMMED   = 3'd3,
    S_FADE_IN  = 3'd4
  } state_e;

endpackage

// File: rtl/pause_fade_scale.sv
// One colour channel of the brightness scaler.
// Registers (c * level) >> 3, truncated to W bits. Level 8 returns c
// unchanged, so full brightness is bit-exact.
// Ports:
//   clk_sys, reset_n : clock, asynchronous active-low reset
//   c                : channel value (already pipeline-registered upstream)
//   level            : brightness in eighths, aligned with c
//   c_out            : scaled channel, one cycle after c
module pause_fade_scale
  import pause_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic [W-1:0]          c,
  input  logic [LEVEL_BITS-1:0] level,
  output logic [W-1:0]          c_out
);

  logic [W+LEVEL_BITS-1:0] prod;
  logic [W-1:0]            out_d;
  logic [W-1:0]            out_q;

  always_comb begin
    prod  = (W+LEVEL_BITS)'(c) * (W+LEVEL_BITS)'(level);
    out_d = W'(prod >> 3);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) out_q <= '0;
    else          out_q <= out_d;
  end

  assign c_out = out_q;

endmodule

// File: rtl/pause_fade.sv
// Pause fade: after pause_cpu has been held for DIM_SECONDS the picture is
// dimmed in frame-synchronous steps down to MIN_LEVEL, and brought back up
// when the pause ends. Video goes through a fixed 2-cycle pipeline.
// Ports:
//   clk_sys, reset_n          : clock, asynchronous active-low reset
//   pause_cpu, enable         : pause request, dim option (0 = always full)
//   r, g, b, hs, vs,
//   hblank, vblank            : input video
//   rgb_out, hs_out, vs_out,
//   hblank_out, vblank_out    : scaled video, 2 cycles behind the inputs
//   level                     : current brightness in eighths (8 = full)
//   dim_active                : level below full
//   state_dbg                 : FSM state, for observation only
// SEC_CYCLES is the prescaler period of one second; it defaults to
// CLKSPD MHz worth of cycles and is only overridden for short simulations.
module pause_fade
  import pause_pkg::*;
#(
  parameter int RW              = 8,
  parameter int GW              = 8,
  parameter int BW              = 8,
  parameter int CLKSPD          = 12,
  parameter int SEC_CYCLES      = CLKSPD * 1_000_000,
  parameter int DIM_SECONDS     = 10,
  parameter int FRAMES_PER_STEP = 4,
  parameter int MIN_LEVEL       = 4
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  pause_cpu,
  input  logic                  enable,
  input  logic [RW-1:0]         r,
  input  logic [GW-1:0]         g,
  input  logic [BW-1:0]         b,
  input  logic                  hs,
  input  logic                  vs,
  input  logic                  hblank,
  input  logic                  vblank,
  output logic [RW+GW+BW-1:0]   rgb_out,
  output logic                  hs_out,
  output logic                  vs_out,
  output logic                  hblank_out,
  output logic                  vblank_out,
  output logic [LEVEL_BITS-1:0] level,
  output logic                  dim_active,
  output state_e                state_dbg
);

  localparam logic [PRESC_BITS-1:0] PRESC_MAX  = PRESC_BITS'(SEC_CYCLES - 1);
  localparam logic [SECS_BITS-1:0]  DIM_SEC    = SECS_BITS'(DIM_SECONDS);
  localparam logic [FRAME_BITS-1:0] FRAME_LAST = FRAME_BITS'(FRAMES_PER_STEP - 1);
  localparam logic [LEVEL_BITS-1:0] MIN_LVL    = LEVEL_BITS'(MIN_LEVEL);

  state_e                state_q, state_d;
  logic [LEVEL_BITS-1:0] level_q, level_d;
  logic [PRESC_BITS-1:0] presc_q, presc_d;
  logic [SECS_BITS-1:0]  secs_q,  secs_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  vblank_q;
  logic                  vb_rise;

  // ---------------- control FSM ----------------
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    presc_d = presc_q;
    secs_d  = secs_q;
    frame_d = frame_q;
    vb_rise = vblank & ~vblank_q;

    if (!enable) begin
      // Dim option off overrides everything, including an active fade.
      state_d = S_IDLE;
      level_d = LEVEL_FULL;
    end else begin
      case (state_q)
        S_IDLE: begin
          level_d = LEVEL_FULL;
          if (pause_cpu) begin
            state_d = S_WAIT;
            presc_d = '0;
            secs_d  = '0;
          end
        end

        S_WAIT: begin
          if (!pause_cpu) begin
            state_d = S_IDLE;
          end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            if (secs_q != '1) secs_d = secs_q + 1'b1;
            if (secs_d == DIM_SEC) begin
              state_d = S_FADE_OUT;
              frame_d = '0;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end

        S_FADE_OUT: begin
          // A pause change beats a coincident vblank rise: no step that cycle.
          if (!pause_cpu) begin
            state_d = S_FADE_IN;
            frame_d = '0;
          end else if (level_q <= MIN_LVL) begin
            // Reversal from FADE_IN can land here already at the floor.
            state_d = S_DIMMED;
          end else if (vb_rise) begin
            if (frame_q == FRAME_LAST) begin
              level_d = level_q - 4'd1;
              frame_d = '0;
              if (level_d == MIN_LVL) state_d = S_DIMMED;
            end else begin
              frame_d = frame_q + 1'b1;
            end
          end
        end

        S_DIMMED: begin
          if (!pause_cpu) begin
            state_d = S_FADE_IN;
            frame_d = '0;
          end
        end

        S_FADE_IN: begin
          if (pause_cpu) begin
            state_d = S_FADE_OUT;
            frame_d = '0;
          end else if (level_q >= LEVEL_FULL) begin
            // Unpaused before the first fade-out step: nothing to ramp.
            state_d = S_IDLE;
            level_d = LEVEL_FULL;
          end else if (vb_rise) begin
            if (frame_q == FRAME_LAST) begin
              level_d = level_q + 4'd1;
              frame_d = '0;
              if (level_d == LEVEL_FULL) state_d = S_IDLE;
            end else begin
              frame_d = frame_q + 1'b1;
            end
          end
        end

        default: begin
          state_d = S_IDLE;
          level_d = LEVEL_FULL;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      level_q  <= LEVEL_FULL;
      presc_q  <= '0;
      secs_q   <= '0;
      frame_q  <= '0;
      vblank_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      presc_q  <= presc_d;
      secs_q   <= secs_d;
      frame_q  <= frame_d;
      vblank_q <= vblank;
    end
  end

  // ---------------- video pipeline ----------------
  // Stage 1 captures colour, sync and level together so a level step
  // always applies to whole pixels; stage 2 is the scaler register.
  logic [RW-1:0]         r_s1_q;
  logic [GW-1:0]         g_s1_q;
  logic [BW-1:0]         b_s1_q;
  logic [LEVEL_BITS-1:0] lvl_s1_q;
  logic [3:0]            sync_s1_q;  // {hs, vs, hblank, vblank}
  logic [3:0]            sync_s2_q;
  logic [RW-1:0]         r_o;
  logic [GW-1:0]         g_o;
  logic [BW-1:0]         b_o;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_q    <= '0;
      g_s1_q    <= '0;
      b_s1_q    <= '0;
      lvl_s1_q  <= LEVEL_FULL;
      sync_s1_q <= 4'b0011;
      sync_s2_q <= 4'b0011;
    end else begin
      r_s1_q    <= r;
      g_s1_q    <= g;
      b_s1_q    <= b;
      lvl_s1_q  <= level_q;
      sync_s1_q <= {hs, vs, hblank, vblank};
      sync_s2_q <= sync_s1_q;
    end
  end

  pause_fade_scale #(.W(RW)) u_scale_r (
    .clk_sys (clk_sys), .reset_n (reset_n), .c (r_s1_q), .level (lvl_s1_q), .c_out (r_o)
  );
  pause_fade_scale #(.W(GW)) u_scale_g (
    .clk_sys (clk_sys), .reset_n (reset_n), .c (g_s1_q), .level (lvl_s1_q), .c_out (g_o)
  );
  pause_fade_scale #(.W(BW)) u_scale_b (
    .clk_sys (clk_sys), .reset_n (reset_n), .c (b_s1_q), .level (lvl_s1_q), .c_out (b_o)
  );

  assign rgb_out    = {r_o, g_o, b_o};
  assign hs_out     = sync_s2_q[3];
  assign vs_out     = sync_s2_q[2];
  assign hblank_out = sync_s2_q[1];
  assign vblank_out = sync_s2_q[0];
  assign level      = level_q;
  assign dim_active = (level_q < LEVEL_FULL);
  assign state_dbg  = state_q;

endmodule

// File: doc/pause_fade.md
# pause_fade

Video-path stage directly downstream of the pause controller. It consumes `pause_cpu` and raw RGB plus sync/blank. After a configurable pause timeout it ramps brightness down in frame-synchronous steps to a floor level, and ramps back up on unpause. It replaces the abrupt halving with a gradual fade and delivers pipeline-aligned video to `arcade_video`.

## Interface
- `RW`, 8, red channel width
- `GW`, 8, green channel width
- `BW`, 8, blue channel width
- `CLKSPD`, 12, clock in MHz; prescaler period = CLKSPD*1_000_000 cycles (one "second")
- `DIM_SECONDS`, 10, paused seconds before fade-out begins (1..255)
- `FRAMES_PER_STEP`, 4, vblank rises per level step (1..255)
- `MIN_LEVEL`, 4, floor brightness in eighths (0..7)

- `clk_sys`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `pause_cpu`  in  1  pause active from pause controller
- `enable`  in  1  OSD dim option; 0 forces full brightness
- `r`/`g`/`b`  in  RW/GW/BW  input colour
- `hs`, `vs`, `hblank`, `vblank`  in  1 each  input sync/blank
- `rgb_out`  out  RW+GW+BW  scaled colour {r,g,b}
- `hs_out`, `vs_out`, `hblank_out`, `vblank_out`  out  1 each  sync/blank delayed to match `rgb_out`
- `level`  out  4  current brightness in eighths (8 = full)
- `dim_active`  out  1  high while `level` < 8

## Operation
- States: IDLE, WAIT, FADE_OUT, DIMMED, FADE_IN.
- IDLE: `level`=8. `pause_cpu & enable` → WAIT; prescaler and seconds counter cleared.
- WAIT: prescaler counts to CLKSPD*1_000_000-1, wraps, increments seconds. Seconds reaching DIM_SECONDS → FADE_OUT. `!pause_cpu` → IDLE.
- FADE_OUT: frame counter (cleared on state entry) increments on each vblank rising edge. On the rise where it equals FRAMES_PER_STEP-1, `level` decrements and the counter clears. `level` reaching MIN_LEVEL → DIMMED. `!pause_cpu` → FADE_IN.
- DIMMED: hold `level`. `!pause_cpu` → FADE_IN.
- FADE_IN: same frame stepping, incrementing. `level` reaching 8 → IDLE. `pause_cpu` → FADE_OUT directly, with no new timeout.
- `enable`=0 in any state → IDLE and `level`=8 on the next edge. This takes priority over all other transitions.
- Vblank edge detect uses a registered `vblank`; a rise is `vblank & !vblank_q`.
- Scaling per channel: out = (c * level) >> 3. The product is W+4 bits and the result is truncated to W bits. Level 8 must reproduce c exactly. Blank periods are scaled like active video; there is no special case.
- Prescaler is 28 bits and seconds counter is 8 bits. Neither may wrap silently; both are held at terminal value outside WAIT.

## Timing
- Video latency is 2 cycles: stage 1 registers r/g/b, sync/blank and `level`; stage 2 registers the scaled result. All sync/blank outputs use the same 2-cycle delay.
- `level` changes take effect on `rgb_out` 2 cycles after the `level` register updates. They occur only on vblank rises, so there is no mid-frame brightness change.
- Reset values: state IDLE, `level`=8, `dim_active`=0, `rgb_out`=0, `hs_out`=`vs_out`=0, `hblank_out`=`vblank_out`=1, all counters 0, `vblank_q`=0.
- Reset assertion mid-fade forces reset values immediately (asynchronous). Release is synchronised externally.
- Simultaneous vblank rise and pause change: the state transition wins and no level step occurs on that cycle.

## Structure
- Shared package `pause_pkg`: state encoding, `LEVEL_FULL`=8, `LEVEL_BITS`=4.
- Sub-module `pause_fade_scale`: parameterised width W, one pipeline register, (c*level)>>3. Instantiated three times.
- Top `pause_fade` holds the FSM, counters and sync delay line.

## Test plan
- Reset: hold `reset_n`=0 → `rgb_out`=0, `level`=8, `dim_active`=0, `hblank_out`=`vblank_out`=1.
- Pass-through: `pause_cpu`=0, r=0xFF g=0x80 b=0x01 → identical `rgb_out` exactly 2 cycles later; `hs` pulse appears on `hs_out` 2 cycles later.
- Fade-out (CLKSPD=1, DIM_SECONDS=1, FRAMES_PER_STEP=4, MIN_LEVEL=4): pause, r=0xFF.
  - No `level` change before 1,000,000 cycles.
  - Then `level` 7 after 4 vblank rises, `rgb_out` red=0xDF.
  - `level` 4 after 16 rises, red=0x7F, state DIMMED.
- Fade-in: from DIMMED drop `pause_cpu` → `level` 5,6,7,8 at every 4th vblank rise; `dim_active`=0 and IDLE at `level` 8.
- Reversal: drop `pause_cpu` at `level` 6 in FADE_OUT → FADE_IN, `level` 7 after 4 rises. Reassert `pause_cpu` → FADE_OUT with no 1 s wait.
- Override: `enable`→0 at `level` 5 → `level`=8 next cycle and red=0xFF two cycles later. Async `reset_n` pulse mid-fade → reset values without a clock edge.
